uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Serial transmitter for the 9600 bps, 8 data bits, odd parity, 1 stop bit (8O1) link used by the LCD-control UART path. It takes byte writes from the bus-side bridge through a WR strobe into a small FIFO and shifts each byte out on TXD with that link's framing. It reports FIFO and line status back to the bridge. It is the native-Verilog transmit end of the link and sits between the bridge's send path and the TxD pin.

## Interface
Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 9600, line bit rate.
- DEPTH, 4, FIFO depth in bytes; must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock, 50 MHz; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- WR  input  1  write strobe; each cycle high pushes DBIN (one byte per high cycle).
- DBIN  input  8  byte to transmit, sampled on a clk edge where WR=1.
- TXD  output  1  serial line output, idle high, registered.
- TBE  output  1  transmit buffer empty: FIFO empty and FSM in IDLE.
- FULL  output  1  FIFO holds DEPTH bytes.
- OE  output  1  sticky overwrite error: a write arrived while FULL.
- LEVEL  output  log2(DEPTH)+1  bytes currently in FIFO, excluding the byte being shifted.

## Operation
- Bit period: DIV = CLK_HZ/BAUD with integer truncation (5208 at defaults). A 13-bit-minimum counter runs 0..DIV-1 and reloads at DIV-1.
- Frame: 11 bits, in this order:
  - start bit 0;
  - D0..D7, LSB first;
  - parity P = ~^D, so the total count of ones in D plus P is odd;
  - stop bit 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TXD=1. If the FIFO is non-empty, pop the head into the shift register, compute P, clear the bit counter and go to START.
- START: TXD=0 for DIV cycles, then go to DATA with bit index 0.
- DATA: TXD=shift[0] for DIV cycles, then shift right.
  - After the 8th bit, go to PARITY.
  - A 3-bit index counts the data bits.
- PARITY: TXD=P for DIV cycles, then go to STOP.
- STOP: TXD=1 for DIV cycles.
  - At the end of stop, if the FIFO is non-empty, pop and go directly to START. There is no idle gap between frames.
  - Otherwise go to IDLE.
- FIFO: circular buffer with read and write pointers of log2(DEPTH)+1 bits. The MSB distinguishes full from empty, and pointers wrap modulo 2·DEPTH.
- Write rules:
  - A write is accepted iff FULL=0 in the same cycle.
  - A write while FULL=1 is dropped and sets OE=1, even if a pop occurs that cycle. The FIFO contents are unchanged.
  - OE clears only on RST.
- Simultaneous write and pop when not full: both take effect and LEVEL is unchanged.
- Write to an empty FIFO while IDLE: the byte goes through the FIFO. There is no bypass.
- Reset (any state, including mid-frame):
  - Takes effect on the next edge: TXD=1, FSM=IDLE, pointers=0, LEVEL=0, FULL=0, OE=0, TBE=1, counters=0.
  - A partial frame is abandoned. The line simply returns high.
  - WR in the reset cycle is ignored.

## Timing
- All outputs are registered except TBE, FULL and LEVEL, which are decoded combinationally from registered pointers and state.
- Latency when idle and empty:
  - Edge N samples WR=1, so LEVEL=1 after N.
  - Edge N+1 pops the byte, so TXD=0 after N+1. This is 1 cycle of latency from write to start bit.
- Each bit lasts exactly DIV clk cycles. A frame is 11·DIV cycles.
- With the FIFO refilled, consecutive start bits are 11·DIV cycles apart.
- TBE rises on the edge that ends the last stop bit with the FIFO empty. It is low throughout any frame.
- FULL asserts the cycle after the write that makes LEVEL=DEPTH. It deasserts the cycle after the next pop.

## Test plan
Bench setting: CLK_HZ=16, BAUD=1 (DIV=16), DEPTH=4, unless a scenario states otherwise.
- Reset value check: hold RST for 3 cycles, then release → TXD=1, TBE=1, FULL=0, OE=0, LEVEL=0.
- Single byte 0x55: one WR pulse, 1 cycle → TXD low 1 cycle later, then data bits 1,0,1,0,1,0,1,0 (16 cycles each), parity 1, stop 1. TBE returns to 1 after 176 cycles.
- Parity coverage: bytes 0x00 → P=1; 0x07 → P=0; 0xFF → P=1; 0x80 → P=0. Each is checked by sampling mid-bit.
- Back-to-back frames: write 0xA3,0x3C,0x01,0xFE in 4 consecutive cycles.
  - The first byte pops 1 cycle after its write, so LEVEL peaks at 3 and FULL stays 0.
  - Start bits are exactly 176 cycles apart, and the bytes arrive in order.
- Overflow: during a frame, write 5 bytes 0x10..0x14 into an already-empty FIFO.
  - LEVEL=4 and FULL=1 after the 4th write.
  - The 5th byte (0x14) is dropped and OE=1.
  - Only 0x10..0x13 are transmitted.
  - OE stays 1 until RST.
- Reset mid-frame: assert RST during DATA bit 3 of 0xF0 with 2 bytes queued → TXD=1 next cycle, LEVEL=0, TBE=1. No further frames follow without new writes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8O1 UART transmitter: byte writes land in a small circular FIFO and are framed
// onto TXD as start, D0..D7 LSB first, odd parity, stop, with no gap between queued frames.
module uart_tx_fifo #(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 9600,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic                     WR,
   input  logic [7:0]               DBIN,
   output logic                     TXD,
   output logic                     TBE,
   output logic                     FULL,
   output logic                     OE,
   output logic [$clog2(DEPTH):0]   LEVEL
);

   localparam int AW  = $clog2(DEPTH);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = ($clog2(DIV) > 13) ? $clog2(DIV) : 13;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] baudCnt;
   logic [2:0]    bitIdx;
   logic [7:0]    shiftReg;
   logic          parityBit;
   logic [7:0]    mem [DEPTH];
   logic [AW:0]   wrPtr;
   logic [AW:0]   rdPtr;

   logic       empty;
   logic       bitEnd;
   logic       push;
   logic       popNow;
   logic [7:0] headByte;

   // WR is a one-cycle push strobe with no back-pressure: a byte is taken on any
   // edge where WR=1 and FULL=0; a WR while FULL is discarded and latches OE.
   assign empty    = (wrPtr == rdPtr);
   assign FULL     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign LEVEL    = wrPtr - rdPtr;
   assign TBE      = empty && (state == IDLE);
   assign bitEnd   = (baudCnt == DIV_LAST);
   assign push     = WR && !FULL;
   assign headByte = mem[rdPtr[AW-1:0]];
   assign popNow   = !empty && ((state == IDLE) || ((state == STOP) && bitEnd));

   always_ff @(posedge clk) begin
      if (!RST && push) begin
         mem[wrPtr[AW-1:0]] <= DBIN;
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= IDLE;
         baudCnt   <= '0;
         bitIdx    <= '0;
         shiftReg  <= '0;
         parityBit <= 1'b0;
         wrPtr     <= '0;
         rdPtr     <= '0;
         TXD       <= 1'b1;
         OE        <= 1'b0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PTR_ONE;
         end
         if (WR && FULL) begin
            OE <= 1'b1;
         end
         if (popNow) begin
            rdPtr <= rdPtr + PTR_ONE;
         end

         case (state)
            IDLE: begin
               baudCnt <= '0;
               TXD     <= 1'b1;
               if (!empty) begin
                  shiftReg  <= headByte;
                  parityBit <= ~^headByte;
                  bitIdx    <= '0;
                  state     <= START;
                  TXD       <= 1'b0;
               end
            end
            START: begin
               if (bitEnd) begin
                  baudCnt <= '0;
                  bitIdx  <= '0;
                  state   <= DATA;
                  TXD     <= shiftReg[0];
               end else begin
                  baudCnt <= baudCnt + CNT_ONE;
               end
            end
            DATA: begin
               if (bitEnd) begin
                  baudCnt  <= '0;
                  shiftReg <= {1'b0, shiftReg[7:1]};
                  if (bitIdx == 3'd7) begin
                     state <= PARITY;
                     TXD   <= parityBit;
                  end else begin
                     bitIdx <= bitIdx + 3'd1;
                     TXD    <= shiftReg[1];
                  end
               end else begin
                  baudCnt <= baudCnt + CNT_ONE;
               end
            end
            PARITY: begin
               if (bitEnd) begin
                  baudCnt <= '0;
                  state   <= STOP;
                  TXD     <= 1'b1;
               end else begin
                  baudCnt <= baudCnt + CNT_ONE;
               end
            end
            STOP: begin
               if (bitEnd) begin
                  baudCnt <= '0;
                  // A queued byte chains straight into the next start bit.
                  if (!empty) begin
                     shiftReg  <= headByte;
                     parityBit <= ~^headByte;
                     bitIdx    <= '0;
                     state     <= START;
                     TXD       <= 1'b0;
                  end else begin
                     state <= IDLE;
                     TXD   <= 1'b1;
                  end
               end else begin
                  baudCnt <= baudCnt + CNT_ONE;
               end
            end
            default: begin
               state   <= IDLE;
               baudCnt <= '0;
               TXD     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=16: framing, parity, chaining,
// overflow and mid-frame reset, with hand-computed expected line values.
module tb_uart_tx_fifo;

   localparam int FRAME = 176;

   logic       clk;
   logic       RST;
   logic       WR;
   logic [7:0] DBIN;
   logic       TXD;
   logic       TBE;
   logic       FULL;
   logic       OE;
   logic [2:0] LEVEL;

   int   cyc = 0;
   int   nVec = 0;
   int   nErr = 0;
   int   startQ[$];
   logic txdPrev = 1'b1;
   logic inFrame = 1'b0;
   int   frameEnd = 0;

   uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DEPTH(4)) dut (
      .clk   (clk),
      .RST   (RST),
      .WR    (WR),
      .DBIN  (DBIN),
      .TXD   (TXD),
      .TBE   (TBE),
      .FULL  (FULL),
      .OE    (OE),
      .LEVEL (LEVEL)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // Records the edge index of each frame's start bit (falling edge outside a frame).
   always @(negedge clk) begin
      if (RST) begin
         inFrame = 1'b0;
      end else begin
         if (inFrame && cyc >= frameEnd) inFrame = 1'b0;
         if (!inFrame && txdPrev === 1'b1 && TXD === 1'b0) begin
            startQ.push_back(cyc);
            inFrame  = 1'b1;
            frameEnd = cyc + FRAME;
         end
      end
      txdPrev = TXD;
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gotoCyc(input int t);
      while (cyc < t) tick();
   endtask

   task automatic writeByte(input logic [7:0] b);
      WR   = 1'b1;
      DBIN = b;
      tick();
      WR   = 1'b0;
   endtask

   task automatic waitFrame(input string tag, output int s);
      int n = 0;
      while (startQ.size() == 0 && n < 400) begin
         tick();
         n++;
      end
      if (startQ.size() == 0) begin
         checkVal({tag, "_timeout"}, 32'd0, 32'd1);
         s = -1;
      end else begin
         s = startQ.pop_front();
      end
   endtask

   task automatic checkFrame(input string tag, input logic [7:0] d, input logic p, output int s);
      waitFrame(tag, s);
      if (s >= 0) begin
         gotoCyc(s + 8);
         checkVal({tag, "_start"}, 32'(TXD), 32'd0);
         for (int i = 0; i < 8; i++) begin
            gotoCyc(s + 8 + 16 * (i + 1));
            checkVal($sformatf("%s_d%0d", tag, i), 32'(TXD), 32'(d[i]));
         end
         gotoCyc(s + 8 + 144);
         checkVal({tag, "_parity"}, 32'(TXD), 32'(p));
         gotoCyc(s + 8 + 160);
         checkVal({tag, "_stop"}, 32'(TXD), 32'd1);
      end
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (TBE !== 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      checkVal({tag, "_idle"}, 32'(TBE), 32'd1);
   endtask

   initial begin
      int s;
      int prev;
      int wrCyc;
      int maxLev;
      int lowCnt;
      logic fullSeen;
      logic [7:0] pd [4];
      logic       pp [4];
      logic [7:0] ovd [5];
      logic       ovp [5];

      RST  = 1'b1;
      WR   = 1'b0;
      DBIN = 8'h00;

      // reset values
      repeat (3) tick();
      RST = 1'b0;
      tick();
      checkVal("rst_txd",   32'(TXD),   32'd1);
      checkVal("rst_tbe",   32'(TBE),   32'd1);
      checkVal("rst_full",  32'(FULL),  32'd0);
      checkVal("rst_oe",    32'(OE),    32'd0);
      checkVal("rst_level", 32'(LEVEL), 32'd0);

      // single byte 0x55: one cycle of latency, P=1, TBE back after 176 cycles
      writeByte(8'h55);
      wrCyc = cyc;
      checkVal("b55_level_w", 32'(LEVEL), 32'd1);
      checkVal("b55_txd_w",   32'(TXD),   32'd1);
      checkVal("b55_tbe_w",   32'(TBE),   32'd0);
      tick();
      checkVal("b55_txd_pop",   32'(TXD),   32'd0);
      checkVal("b55_level_pop", 32'(LEVEL), 32'd0);
      checkFrame("b55", 8'h55, 1'b1, s);
      checkVal("b55_latency", 32'(s), 32'(wrCyc + 1));
      gotoCyc(wrCyc + FRAME);
      checkVal("b55_tbe_busy", 32'(TBE), 32'd0);
      tick();
      checkVal("b55_tbe_done", 32'(TBE), 32'd1);
      checkVal("b55_txd_done", 32'(TXD), 32'd1);

      // parity coverage, written back to back
      pd = '{8'h00, 8'h07, 8'hFF, 8'h80};
      pp = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) writeByte(pd[i]);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         checkFrame($sformatf("par%0d", i), pd[i], pp[i], s);
         if (i > 0) checkVal($sformatf("par%0d_gap", i), 32'(s - prev), 32'(FRAME));
         prev = s;
      end
      waitIdle("par");

      // back-to-back: LEVEL peaks at 3, FULL never set, 176-cycle spacing
      maxLev   = 0;
      fullSeen = 1'b0;
      pd = '{8'hA3, 8'h3C, 8'h01, 8'hFE};
      pp = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         writeByte(pd[i]);
         if (int'(LEVEL) > maxLev) maxLev = int'(LEVEL);
         if (FULL === 1'b1) fullSeen = 1'b1;
      end
      checkVal("b2b_maxlevel", 32'(maxLev),   32'd3);
      checkVal("b2b_full",     32'(fullSeen), 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkFrame($sformatf("b2b%0d", i), pd[i], pp[i], s);
         if (i > 0) checkVal($sformatf("b2b%0d_gap", i), 32'(s - prev), 32'(FRAME));
         prev = s;
      end
      waitIdle("b2b");

      // overflow: frame 0x99 in flight, then 0x10..0x14 into the empty FIFO
      writeByte(8'h99);
      tick();
      checkVal("ov_level0", 32'(LEVEL), 32'd0);
      ovd = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      for (int i = 0; i < 4; i++) begin
         writeByte(ovd[i]);
         checkVal($sformatf("ov_level%0d", i + 1), 32'(LEVEL), 32'(i + 1));
         checkVal($sformatf("ov_full%0d", i + 1), 32'(FULL), 32'(i == 3));
         checkVal($sformatf("ov_oe%0d", i + 1), 32'(OE), 32'd0);
      end
      writeByte(ovd[4]);
      checkVal("ov_level5", 32'(LEVEL), 32'd4);
      checkVal("ov_full5",  32'(FULL),  32'd1);
      checkVal("ov_oe5",    32'(OE),    32'd1);
      checkFrame("ov99", 8'h99, 1'b1, s);
      prev = s;
      ovp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         checkFrame($sformatf("ov%0d", i), ovd[i], ovp[i], s);
         checkVal($sformatf("ov%0d_gap", i), 32'(s - prev), 32'(FRAME));
         prev = s;
      end
      waitIdle("ov");
      repeat (200) tick();
      checkVal("ov_no_extra", 32'(startQ.size()), 32'd0);
      checkVal("ov_oe_sticky", 32'(OE), 32'd1);

      // reset during DATA bit 3 of 0xF0 with two bytes queued
      writeByte(8'hF0);
      writeByte(8'h11);
      writeByte(8'h22);
      checkVal("mr_level_q", 32'(LEVEL), 32'd2);
      waitFrame("mr", s);
      if (s >= 0) gotoCyc(s + 72);
      checkVal("mr_bit3",  32'(TXD), 32'd0);
      checkVal("mr_tbe_b", 32'(TBE), 32'd0);
      checkVal("mr_oe_b",  32'(OE),  32'd1);
      RST  = 1'b1;
      WR   = 1'b1;
      DBIN = 8'h5A;
      tick();
      checkVal("mr_txd",   32'(TXD),   32'd1);
      checkVal("mr_level", 32'(LEVEL), 32'd0);
      checkVal("mr_tbe",   32'(TBE),   32'd1);
      checkVal("mr_full",  32'(FULL),  32'd0);
      checkVal("mr_oe",    32'(OE),    32'd0);
      RST = 1'b0;
      WR  = 1'b0;
      lowCnt = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (TXD !== 1'b1) lowCnt++;
      end
      checkVal("mr_line_quiet", 32'(lowCnt), 32'd0);
      checkVal("mr_no_frames",  32'(startQ.size()), 32'd0);
      checkVal("mr_level_end",  32'(LEVEL), 32'd0);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
